// File: rtl/memory_stage_unit_if.sv
// Data-memory handshake bundle between the MEM stage and the data memory.
// The MEM stage is the master: it raises mem_req with address/data/mask and
// holds them until the memory answers with mem_ack (plus mem_rdata on reads).
interface memory_stage_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wmask,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wmask,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/memory_stage_unit.sv
// MEM stage of the 5-stage pipeline. Issues byte/doubleword accesses on a
// variable-latency req/ack memory port, stalls the front of the pipeline
// while an access is outstanding, aborts accesses that never get an ack,
// and registers the writeback result into the MEM/WB pipeline register.
module memory_stage_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [63:0]          ALUResult_EXRegister,
    input  logic [63:0]          WrData_EXRegister,
    input  logic [4:0]           Rd_EXRegister,
    input  logic                 MemWrite_EXRegister,
    input  logic                 MemToReg_EXRegister,
    input  logic                 RegWrite_EXRegister,
    input  logic                 ByteOp_EXRegister,
    memory_stage_unit_if.master  mem,
    output logic                 stall_MEM,
    output logic [63:0]          Result_MEMRegister,
    output logic [4:0]           Rd_MEMRegister,
    output logic                 RegWrite_MEMRegister,
    output logic                 fault_MEMRegister
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Replicate the store byte into every lane for byte stores.
    function automatic logic [63:0] store_lanes(input logic byte_op, input logic [63:0] data);
        if (byte_op) begin
            return {8{data[7:0]}};
        end else begin
            return data;
        end
    endfunction

    // Byte enables for a store of the given size at the given lane.
    function automatic logic [7:0] store_mask(input logic byte_op, input logic [2:0] off);
        if (byte_op) begin
            return 8'h01 << off;
        end else begin
            return 8'hFF;
        end
    endfunction

    // Pick the addressed lane (zero-extended) for byte loads.
    function automatic logic [63:0] load_extract(input logic byte_op, input logic [2:0] off,
                                                 input logic [63:0] rdata);
        if (byte_op) begin
            return {56'h0, rdata[{off, 3'b000} +: 8]};
        end else begin
            return rdata;
        end
    endfunction

    logic [0:0]       state_r;
    logic [CNT_W-1:0] cnt_r;

    // Holding registers: the in-flight access, stable for the whole wait.
    logic [63:0] hold_addr_r;
    logic [63:0] hold_wdata_r;
    logic [7:0]  hold_wmask_r;
    logic        hold_we_r;
    logic        hold_load_r;
    logic        hold_byte_r;
    logic [4:0]  hold_rd_r;
    logic        hold_regwrite_r;

    logic [63:0] result_r;
    logic [4:0]  rd_r;
    logic        regwrite_r;
    logic        fault_r;

    logic        memop_s;
    logic        misaligned_s;
    logic        in_wait_s;
    logic        issue_s;
    logic        complete_s;
    logic        timeout_s;
    logic        stall_s;
    logic        cur_store_s;
    logic [63:0] cur_wdata_s;
    logic [7:0]  cur_wmask_s;
    logic [63:0] sel_addr_s;
    logic        sel_load_s;
    logic        sel_byte_s;
    logic [4:0]  sel_rd_s;
    logic        sel_regwrite_s;
    logic        req_s;
    logic        we_s;
    logic [63:0] addr_s;
    logic [63:0] wdata_s;
    logic [7:0]  wmask_s;

    // Decode the EX/MEM instruction and the current handshake situation.
    always_comb begin
        memop_s      = MemWrite_EXRegister | MemToReg_EXRegister;
        misaligned_s = memop_s & ~ByteOp_EXRegister & (ALUResult_EXRegister[2:0] != 3'b000);
        in_wait_s    = (state_r == ST_WAIT);
        issue_s      = (state_r == ST_IDLE) & memop_s & ~misaligned_s;
        complete_s   = (issue_s | in_wait_s) & mem.mem_ack;
        timeout_s    = in_wait_s & ~mem.mem_ack & (cnt_r == TIMEOUT_CNT);
        stall_s      = reset & ((issue_s & ~mem.mem_ack) |
                                (in_wait_s & ~mem.mem_ack & ~timeout_s));
        cur_store_s  = MemWrite_EXRegister;
        if (cur_store_s) begin
            cur_wdata_s = store_lanes(ByteOp_EXRegister, WrData_EXRegister);
            cur_wmask_s = store_mask(ByteOp_EXRegister, ALUResult_EXRegister[2:0]);
        end else begin
            cur_wdata_s = 64'h0;
            cur_wmask_s = 8'h00;
        end
    end

    // Select the access being completed: the held one in WAIT, else the live inputs.
    always_comb begin
        if (in_wait_s) begin
            sel_addr_s     = hold_addr_r;
            sel_load_s     = hold_load_r;
            sel_byte_s     = hold_byte_r;
            sel_rd_s       = hold_rd_r;
            sel_regwrite_s = hold_regwrite_r;
        end else begin
            sel_addr_s     = ALUResult_EXRegister;
            sel_load_s     = MemToReg_EXRegister & ~MemWrite_EXRegister;
            sel_byte_s     = ByteOp_EXRegister;
            sel_rd_s       = Rd_EXRegister;
            sel_regwrite_s = RegWrite_EXRegister & ~MemWrite_EXRegister;
        end
    end

    // Drive the memory port; everything is forced low while reset is asserted.
    always_comb begin
        req_s   = 1'b0;
        we_s    = 1'b0;
        addr_s  = 64'h0;
        wdata_s = 64'h0;
        wmask_s = 8'h00;
        if (!reset) begin
            req_s = 1'b0;
        end else if (in_wait_s) begin
            req_s   = 1'b1;
            we_s    = hold_we_r;
            addr_s  = {hold_addr_r[63:3], 3'b000};
            wdata_s = hold_wdata_r;
            wmask_s = hold_wmask_r;
        end else if (issue_s) begin
            req_s   = 1'b1;
            we_s    = cur_store_s;
            addr_s  = {ALUResult_EXRegister[63:3], 3'b000};
            wdata_s = cur_wdata_s;
            wmask_s = cur_wmask_s;
        end else begin
            req_s = 1'b0;
        end
    end

    assign mem.mem_req   = req_s;
    assign mem.mem_we    = we_s;
    assign mem.mem_addr  = addr_s;
    assign mem.mem_wdata = wdata_s;
    assign mem.mem_wmask = wmask_s;
    assign stall_MEM     = stall_s;

    // IDLE/WAIT sequencing and the wait-cycle counter used for the timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_s && !mem.mem_ack) begin
                        state_r <= ST_WAIT;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem.mem_ack || timeout_s) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= ST_WAIT;
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Capture the access when it is first issued so WAIT can replay it unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_addr_r     <= 64'h0;
            hold_wdata_r    <= 64'h0;
            hold_wmask_r    <= 8'h00;
            hold_we_r       <= 1'b0;
            hold_load_r     <= 1'b0;
            hold_byte_r     <= 1'b0;
            hold_rd_r       <= 5'd0;
            hold_regwrite_r <= 1'b0;
        end else if (issue_s) begin
            hold_addr_r     <= ALUResult_EXRegister;
            hold_wdata_r    <= cur_wdata_s;
            hold_wmask_r    <= cur_wmask_s;
            hold_we_r       <= cur_store_s;
            hold_load_r     <= MemToReg_EXRegister & ~MemWrite_EXRegister;
            hold_byte_r     <= ByteOp_EXRegister;
            hold_rd_r       <= Rd_EXRegister;
            hold_regwrite_r <= RegWrite_EXRegister & ~MemWrite_EXRegister;
        end else begin
            hold_addr_r     <= hold_addr_r;
            hold_wdata_r    <= hold_wdata_r;
            hold_wmask_r    <= hold_wmask_r;
            hold_we_r       <= hold_we_r;
            hold_load_r     <= hold_load_r;
            hold_byte_r     <= hold_byte_r;
            hold_rd_r       <= hold_rd_r;
            hold_regwrite_r <= hold_regwrite_r;
        end
    end

    // MEM/WB register: completion, abort, bubble, misalignment fault or pass-through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_r   <= 64'h0;
            rd_r       <= 5'd0;
            regwrite_r <= 1'b0;
            fault_r    <= 1'b0;
        end else if (complete_s) begin
            if (sel_load_s) begin
                result_r <= load_extract(sel_byte_s, sel_addr_s[2:0], mem.mem_rdata);
            end else begin
                result_r <= sel_addr_s;
            end
            rd_r       <= sel_rd_s;
            regwrite_r <= sel_regwrite_s;
            fault_r    <= 1'b0;
        end else if (timeout_s) begin
            result_r   <= 64'h0;
            rd_r       <= 5'd0;
            regwrite_r <= 1'b0;
            fault_r    <= 1'b1;
        end else if (stall_s) begin
            result_r   <= 64'h0;
            rd_r       <= 5'd0;
            regwrite_r <= 1'b0;
            fault_r    <= 1'b0;
        end else if (misaligned_s) begin
            result_r   <= 64'h0;
            rd_r       <= Rd_EXRegister;
            regwrite_r <= 1'b0;
            fault_r    <= 1'b1;
        end else if (!memop_s) begin
            result_r   <= ALUResult_EXRegister;
            rd_r       <= Rd_EXRegister;
            regwrite_r <= RegWrite_EXRegister;
            fault_r    <= 1'b0;
        end else begin
            result_r   <= 64'h0;
            rd_r       <= 5'd0;
            regwrite_r <= 1'b0;
            fault_r    <= 1'b0;
        end
    end

    assign Result_MEMRegister   = result_r;
    assign Rd_MEMRegister       = rd_r;
    assign RegWrite_MEMRegister = regwrite_r;
    assign fault_MEMRegister    = fault_r;

endmodule

// File: tb/tb_memory_stage_unit.sv
// Self-checking bench for memory_stage_unit: directed cases followed by a
// randomized instruction stream, each checked against a per-instruction
// behavioural model of the MEM stage and its memory handshake.
module tb_memory_stage_unit;

    localparam int TMO = 16;
    localparam int NO_ACK = 1000;

    logic        clk;
    logic        reset;
    logic [63:0] alu_result;
    logic [63:0] wr_data;
    logic [4:0]  rd;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        byte_op;
    logic        stall;
    logic [63:0] wb_result;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        wb_fault;

    int errors = 0;
    int checks = 0;

    memory_stage_unit_if mif ();

    memory_stage_unit #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
        .clk                  (clk),
        .reset                (reset),
        .ALUResult_EXRegister (alu_result),
        .WrData_EXRegister    (wr_data),
        .Rd_EXRegister        (rd),
        .MemWrite_EXRegister  (mem_write),
        .MemToReg_EXRegister  (mem_to_reg),
        .RegWrite_EXRegister  (reg_write),
        .ByteOp_EXRegister    (byte_op),
        .mem                  (mif),
        .stall_MEM            (stall),
        .Result_MEMRegister   (wb_result),
        .Rd_MEMRegister       (wb_rd),
        .RegWrite_MEMRegister (wb_regwrite),
        .fault_MEMRegister    (wb_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Issue one instruction from EX/MEM and follow it to its writeback edge.
    // ack_delay = cycles after the first request cycle until mem_ack (NO_ACK = never).
    task automatic exec_instr(input logic mw, input logic mr, input logic rw, input logic bo,
                              input logic [63:0] addr, input logic [63:0] wd,
                              input logic [4:0] rdi, input int ack_delay,
                              input logic [63:0] rdata);
        logic        memop;
        logic        misal;
        logic        is_store;
        logic        is_load;
        int          off;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [63:0] exp_mask;
        logic [63:0] exp_res;
        logic        ack_now;
        logic        exp_stall;
        @(negedge clk);
        mem_write  = mw;
        mem_to_reg = mr;
        reg_write  = rw;
        byte_op    = bo;
        alu_result = addr;
        wr_data    = wd;
        rd         = rdi;
        mif.mem_ack   = 1'($urandom_range(0, 1));
        mif.mem_rdata = rnd64();
        memop    = mw | mr;
        is_store = mw;
        is_load  = mr & ~mw;
        off      = int'(addr[2:0]);
        misal    = memop & ~bo & (off != 0);
        if (!memop || misal) begin
            #1;
            check("req_low", 64'(mif.mem_req), 64'd0);
            check("stall_low", 64'(stall), 64'd0);
            @(posedge clk);
            #1;
            if (!memop) begin
                check("pass_result", wb_result, addr);
                check("pass_rd", 64'(wb_rd), 64'(rdi));
                check("pass_rw", 64'(wb_regwrite), 64'(rw));
                check("pass_fault", 64'(wb_fault), 64'd0);
            end else begin
                check("misal_rw", 64'(wb_regwrite), 64'd0);
                check("misal_fault", 64'(wb_fault), 64'd1);
            end
        end else begin
            exp_addr = addr & ~64'h7;
            if (is_store && bo) begin
                exp_wdata = {56'h0, wd[7:0]} * 64'h0101_0101_0101_0101;
                exp_mask  = 64'h1 << off;
            end else if (is_store) begin
                exp_wdata = wd;
                exp_mask  = 64'hFF;
            end else begin
                exp_wdata = 64'h0;
                exp_mask  = 64'h0;
            end
            if (is_load && bo) begin
                exp_res = (rdata >> (8 * off)) & 64'hFF;
            end else if (is_load) begin
                exp_res = rdata;
            end else begin
                exp_res = addr;
            end
            for (int k = 0; k <= TMO; k++) begin
                if (k > 0) @(negedge clk);
                ack_now = (k == ack_delay);
                mif.mem_ack   = ack_now;
                mif.mem_rdata = ack_now ? rdata : rnd64();
                #1;
                exp_stall = !ack_now && (k < TMO);
                check("req_high", 64'(mif.mem_req), 64'd1);
                check("addr", mif.mem_addr, exp_addr);
                check("we", 64'(mif.mem_we), 64'(is_store));
                check("wmask", 64'(mif.mem_wmask), exp_mask);
                if (is_store) check("wdata", mif.mem_wdata, exp_wdata);
                check("stall", 64'(stall), 64'(exp_stall));
                @(posedge clk);
                #1;
                if (ack_now) begin
                    check("wb_result", wb_result, exp_res);
                    check("wb_rd", 64'(wb_rd), 64'(rdi));
                    check("wb_rw", 64'(wb_regwrite), 64'(rw & ~mw));
                    check("wb_fault", 64'(wb_fault), 64'd0);
                    break;
                end else if (k == TMO) begin
                    check("abort_rw", 64'(wb_regwrite), 64'd0);
                    check("abort_fault", 64'(wb_fault), 64'd1);
                    @(negedge clk);
                    mem_write   = 1'b0;
                    mem_to_reg  = 1'b0;
                    mif.mem_ack = 1'b0;
                    #1;
                    check("abort_req_drop", 64'(mif.mem_req), 64'd0);
                end else begin
                    check("bubble_rw", 64'(wb_regwrite), 64'd0);
                    check("bubble_fault", 64'(wb_fault), 64'd0);
                end
            end
        end
    endtask

    initial begin
        // Reset held low with a memory op and ack present.
        reset       = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b1;
        reg_write   = 1'b1;
        byte_op     = 1'b0;
        alu_result  = 64'h100;
        wr_data     = 64'h0;
        rd          = 5'd3;
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", 64'(mif.mem_req), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_addr", mif.mem_addr, 64'd0);
        check("rst_result", wb_result, 64'd0);
        check("rst_rd", 64'(wb_rd), 64'd0);
        check("rst_rw", 64'(wb_regwrite), 64'd0);
        check("rst_fault", 64'(wb_fault), 64'd0);
        mem_to_reg = 1'b0;
        reset      = 1'b1;

        // ADD pass-through.
        exec_instr(1'b0, 1'b0, 1'b1, 1'b0, 64'h1234, 64'h0, 5'd5, 0, 64'h0);
        // LDUR 0x100, ack after 3 cycles.
        exec_instr(1'b0, 1'b1, 1'b1, 1'b0, 64'h100, 64'h0, 5'd7, 3, 64'hDEADBEEF_CAFEF00D);
        // STURB 0x203, ack same cycle.
        exec_instr(1'b1, 1'b0, 1'b0, 1'b1, 64'h203, 64'h1122_3344_5566_77AB, 5'd9, 0, 64'h0);
        // LDURB 0x105.
        exec_instr(1'b0, 1'b1, 1'b1, 1'b1, 64'h105, 64'h0, 5'd10, 1, 64'h0000_9900_0000_0000);
        // LDUR 0x104 misaligned, then a clean op that must clear the fault.
        exec_instr(1'b0, 1'b1, 1'b1, 1'b0, 64'h104, 64'h0, 5'd11, 0, 64'h0);
        exec_instr(1'b0, 1'b0, 1'b1, 1'b0, 64'h55, 64'h0, 5'd12, 0, 64'h0);
        // Both MemWrite and MemToReg: behaves as a store.
        exec_instr(1'b1, 1'b1, 1'b1, 1'b0, 64'h308, 64'hA5A5_0000_1111_2222, 5'd13, 2, 64'h0);
        // Load with no ack: timeout abort.
        exec_instr(1'b0, 1'b1, 1'b1, 1'b0, 64'h400, 64'h0, 5'd14, NO_ACK, 64'h0);
        // Ack on the very last WAIT cycle wins over the timeout.
        exec_instr(1'b0, 1'b1, 1'b1, 1'b0, 64'h408, 64'h0, 5'd15, TMO, 64'h0123_4567_89AB_CDEF);

        // Randomized instruction stream.
        for (int n = 0; n < 150; n++) begin
            logic        mw;
            logic        mr;
            logic [63:0] a;
            int          dly;
            int          kind;
            kind = int'($urandom_range(0, 3));
            mw = (kind == 2) || (kind == 3);
            mr = (kind == 1) || (kind == 3);
            a  = rnd64();
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
            dly = ($urandom_range(0, 24) == 0) ? NO_ACK : int'($urandom_range(0, 4));
            exec_instr(mw, mr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                       rnd64(), 5'($urandom_range(0, 31)), dly, rnd64());
        end

        // Reset asserted on WAIT cycle 2.
        @(negedge clk);
        mem_write   = 1'b0;
        mem_to_reg  = 1'b1;
        byte_op     = 1'b0;
        alu_result  = 64'h600;
        mif.mem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("wait2_req", 64'(mif.mem_req), 64'd1);
        reset = 1'b0;
        #1;
        check("midrst_req", 64'(mif.mem_req), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        reset      = 1'b1;
        mem_to_reg = 1'b0;
        #1;
        check("post_rst_req", 64'(mif.mem_req), 64'd0);
        exec_instr(1'b0, 1'b0, 1'b1, 1'b0, 64'h77, 64'h0, 5'd21, 0, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_stage_unit.md
Name:
memory_stage_unit

Overview:
MEM stage of the 5-stage pipeline. It consumes the EX/MEM pipeline register outputs and drives a handshaked data-memory port (req/ack, variable latency, byte or doubleword). It stalls the front of the pipeline while an access is outstanding and registers the writeback result, destination, RegWrite and fault into the MEM/WB pipeline register.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in WAIT without mem_ack before the access is aborted (≥2)
CNT_W, 5, width of the wait counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
ALUResult_EXRegister  input  64  effective address (memory op) or ALU result (non-memory op)
WrData_EXRegister  input  64  store data
Rd_EXRegister  input  5  destination register
MemWrite_EXRegister  input  1  store
MemToReg_EXRegister  input  1  load
RegWrite_EXRegister  input  1  instruction writes Rd
ByteOp_EXRegister  input  1  1 = byte access (LDURB/STURB), 0 = doubleword
mem_rdata  input  64  read data, valid with mem_ack
mem_ack  input  1  access complete this cycle
mem_req  output  1  access request, held until ack
mem_we  output  1  1 = write
mem_addr  output  64  doubleword-aligned address: {addr[63:3],3'b000}
mem_wdata  output  64  write data, byte-lane aligned
mem_wmask  output  8  byte enables
stall_MEM  output  1  combinational; 1 = hold PC, IF/ID, ID/EX, EX/MEM (EX/MEM enable = ~stall_MEM)
Result_MEMRegister  output  64  writeback value
Rd_MEMRegister  output  5  writeback destination
RegWrite_MEMRegister  output  1  writeback enable
fault_MEMRegister  output  1  one-cycle flag: misaligned or timed-out access

Behaviour:
- memop = MemWrite_EXRegister | MemToReg_EXRegister. If both are set, treat as a store: no register write from memory, and the RegWrite input is ignored.
- misaligned = memop & ~ByteOp & (addr[2:0] != 0). This never issues mem_req. Next edge: RegWrite_MEMRegister=0, fault_MEMRegister=1, no stall.
- FSM has two states, IDLE and WAIT. Reset enters IDLE, clears the counter, and sets all registered outputs to 0. Combinational memory outputs are 0 while in reset.
- IDLE, aligned memop: mem_req=1 in the same cycle, with addr/we/wdata/wmask driven from the inputs and captured into holding regs at the edge.
  - If mem_ack is also 1 this cycle: the access completes with zero stall.
  - Otherwise: stall_MEM=1, go to WAIT, counter=1.
- WAIT: mem_req=1, and address, data, mask and we come from the holding regs (stable until ack).
  - stall_MEM = ~mem_ack.
  - On mem_ack: complete, return to IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES, abort: drop mem_req next cycle, go to IDLE, write a bubble with fault_MEMRegister=1, and deassert stall_MEM in that abort cycle.
- While stalled, each edge loads a bubble: RegWrite_MEMRegister=0, fault_MEMRegister=0.
- Completion edge:
  - Load: Result = doubleword mem_rdata, or byte lane addr[2:0] zero-extended.
  - Store: Result = address.
  - Rd_MEMRegister = Rd. RegWrite_MEMRegister = RegWrite & ~MemWrite.
- Non-memory op: 1-cycle latency pass-through. Result = ALUResult, Rd/RegWrite copied, fault=0.
- Doubleword store: wmask=8'hFF, wdata=WrData.
- Byte store: wmask = 1<<addr[2:0], wdata = WrData[7:0] replicated into all 8 lanes.
- Any read: mem_we=0, wmask=0.
- mem_ack while mem_req=0 is ignored. An ack in the same cycle as a timeout abort counts as completion; ack has priority over timeout.
- Reset asserted mid-WAIT: mem_req drops immediately (asynchronous) and the access is abandoned. After release, the unit is in IDLE.
- fault_MEMRegister is high for exactly one cycle per faulting instruction, then clears on the next non-faulting edge.

Test Plan:
- Reset held low with mem_ack=1 → all outputs 0, mem_req=0. After release, ADD with ALUResult=0x1234, Rd=5, RegWrite=1 → next edge Result=0x1234, Rd=5, RegWrite=1, stall_MEM=0.
- LDUR addr=0x100, ack 3 cycles after req, mem_rdata=0xDEADBEEF_CAFEF00D → stall_MEM high for 3 cycles with mem_addr stable at 0x100 and bubbles written. Completion writes Result=0xDEADBEEFCAFEF00D.
- STURB addr=0x203, WrData=0x...AB, ack in the same cycle → wmask=8'h08, mem_addr=0x200, wdata lane 3=0xAB, stall_MEM=0, RegWrite_MEMRegister=0.
- LDURB addr=0x105, mem_rdata=0x0000_9900_0000_0000 → Result=0x99.
- LDUR addr=0x104 → mem_req never asserted, fault_MEMRegister=1 for one cycle, RegWrite_MEMRegister=0.
- Load with no ack (TIMEOUT_CYCLES=16) → stall for 16 cycles, then abort: fault=1, mem_req=0. A separate run asserting reset at WAIT cycle 2 → mem_req=0 immediately and state returns to IDLE.
